// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants and the fetch-buffer entry layout for the instruction
// prefetch queue.
package if_prefetch_queue_pkg;

    localparam logic [31:0] IF_RESET_PC = 32'h1c00_0000;
    localparam logic [1:0]  SIZE_WORD   = 2'b10;
    localparam logic [5:0]  ECODE_ADE   = 6'h08;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } if_entry_t;

    localparam int IF_ENTRY_W = $bits(if_entry_t);

endpackage

// File: rtl/if_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with occupancy count and a synchronous clear that
// takes priority over push and pop.
module if_prefetch_queue_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && !clear && push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    // Writing a full FIFO without a simultaneous pop, or popping an empty one,
    // means the upstream flow control is broken.
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(!clear && push && !pop && count == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(!clear && pop && count == '0));

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction fetch stage: pipelined requests on the SRAM-like port, a PC FIFO
// tracking outstanding requests, and a fetch buffer feeding ID.
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          BUF_DEPTH       = 4,
    parameter logic [31:0] RESET_PC        = IF_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [31:0] if_to_id_inst,
    output logic [31:0] if_to_id_pc,
    output logic        if_to_id_adef
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BUF_W = $clog2(BUF_DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic [OUT_W-1:0] out_cnt;
    logic [OUT_W-1:0] disc_cnt;
    logic [OUT_W-1:0] pc_cnt;
    logic [BUF_W-1:0] buf_cnt;
    logic             halted;

    logic             redirect;
    logic [31:0]      target;
    logic             aligned;
    logic [31:0]      live_sum;
    logic             credit_ok;
    logic             fire;
    logic             resp_live;
    logic             adef_push;
    logic             buf_push;
    logic             buf_pop;
    logic [31:0]      resp_pc;
    if_entry_t        buf_in;
    if_entry_t        buf_head;

    assign redirect = flush | br_taken;
    assign target   = flush ? flush_target : br_target;
    assign aligned  = (fetch_pc[1:0] == 2'b00);

    // Live (non-discarded) in-flight responses plus buffered entries must fit
    // in the buffer, so a live data_ok always finds a free slot.
    assign live_sum  = 32'(out_cnt) - 32'(disc_cnt) + 32'(buf_cnt);
    assign credit_ok = (live_sum < 32'(BUF_DEPTH));

    assign inst_sram_req = resetn & ~redirect & ~halted & aligned & credit_ok
                         & (32'(out_cnt) < 32'(MAX_OUTSTANDING));
    assign fire      = inst_sram_req & inst_sram_addr_ok;
    assign resp_live = inst_sram_data_ok & (disc_cnt == '0) & ~redirect;
    assign adef_push = resetn & ~redirect & ~halted & ~aligned & credit_ok;
    assign buf_push  = resp_live | adef_push;
    assign buf_pop   = if_to_id_valid & id_allowin & ~redirect;

    always_comb begin
        buf_in = '{pc: fetch_pc, inst: 32'h0, adef: 1'b1};
        if (resp_live) buf_in = '{pc: resp_pc, inst: inst_sram_rdata, adef: 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            out_cnt  <= '0;
            disc_cnt <= '0;
            halted   <= 1'b0;
        end else begin
            if (redirect)  fetch_pc <= target;
            else if (fire) fetch_pc <= fetch_pc + 32'd4;

            case ({fire, inst_sram_data_ok})
                2'b10:   out_cnt <= out_cnt + OUT_W'(1);
                2'b01:   out_cnt <= out_cnt - OUT_W'(1);
                default: out_cnt <= out_cnt;
            endcase

            // A response landing in the redirect cycle is already gone, so it
            // is not counted among the ones left to discard.
            if (redirect)
                disc_cnt <= out_cnt - OUT_W'(inst_sram_data_ok);
            else if (inst_sram_data_ok && disc_cnt != '0)
                disc_cnt <= disc_cnt - OUT_W'(1);

            if (redirect)       halted <= 1'b0;
            else if (adef_push) halted <= 1'b1;
        end
    end

    if_prefetch_queue_sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (1'b0),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (inst_sram_data_ok),
        .head      (resp_pc),
        .count     (pc_cnt)
    );

    if_prefetch_queue_sync_fifo #(
        .WIDTH (IF_ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (redirect),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_cnt)
    );

    a_pc_fifo_tracks_out: assert property (@(posedge clk) disable iff (!resetn)
        pc_cnt == out_cnt);
    a_disc_le_out: assert property (@(posedge clk) disable iff (!resetn)
        disc_cnt <= out_cnt);

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = SIZE_WORD;
    assign inst_sram_addr  = resetn ? fetch_pc : 32'h0;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign if_to_id_valid = (buf_cnt != '0);
    assign if_to_id_pc    = if_to_id_valid ? buf_head.pc   : 32'h0;
    assign if_to_id_inst  = if_to_id_valid ? buf_head.inst : 32'h0;
    assign if_to_id_adef  = if_to_id_valid & buf_head.adef;

endmodule
